// File: rtl/universal_shift_register.sv
// Universal shift register (hold / shift L / shift R / load) with an autonomous burst mode.
// Optional rotate feature enabled by defining USR_ROTATE_EN.
module universal_shift_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] parallelIn,
  input  logic             serialInL,
  input  logic             serialInR,
  input  logic             start,
  input  logic [CNT_W-1:0] shiftLen,
  input  logic             dir,
  input  logic             rotate,
  output logic [WIDTH-1:0] parallelOut,
  output logic             serialOutL,
  output logic             serialOutR,
  output logic             busy,
  output logic             done,
  output logic             o_dbg_state
);

  // Handshake: start is a level sampled only in IDLE; a start seen while busy is dropped.
  // done is a one-cycle pulse that coincides with the first IDLE cycle after a burst.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] r_rem;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_n;
  logic [WIDTH-1:0] w_reg_n;
  logic [CNT_W-1:0] w_rem_n;
  logic             w_dir_n;
  logic             w_busy_n;
  logic             w_done_n;

  logic             w_in_l;
  logic             w_in_r;
  logic [CNT_W-1:0] w_eff_len;

`ifdef USR_ROTATE_EN
  assign w_in_l = rotate ? r_reg[WIDTH-1] : serialInL;
  assign w_in_r = rotate ? r_reg[0]       : serialInR;
`else
  logic w_unused_rotate;
  assign w_unused_rotate = rotate;
  assign w_in_l = serialInL;
  assign w_in_r = serialInR;
`endif

  // Requested lengths beyond the register width saturate.
  assign w_eff_len = (shiftLen > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shiftLen;

  always_comb begin
    w_state_n = r_state;
    w_reg_n   = r_reg;
    w_rem_n   = r_rem;
    w_dir_n   = r_dir;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_eff_len != '0) begin
            w_state_n = S_BURST;
            w_rem_n   = w_eff_len;
            w_dir_n   = dir;
            w_busy_n  = 1'b1;
          end else begin
            w_done_n  = 1'b1;
          end
        end else begin
          case (mode)
            2'b01:   w_reg_n = {r_reg[WIDTH-2:0], w_in_l};
            2'b10:   w_reg_n = {w_in_r, r_reg[WIDTH-1:1]};
            2'b11:   w_reg_n = parallelIn;
            default: w_reg_n = r_reg;
          endcase
        end
      end
      S_BURST: begin
        w_reg_n = r_dir ? {w_in_r, r_reg[WIDTH-1:1]} : {r_reg[WIDTH-2:0], w_in_l};
        w_rem_n = r_rem - CNT_W'(1);
        if (r_rem == CNT_W'(1)) begin
          w_state_n = S_IDLE;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_reg   <= RESET_VAL;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_reg   <= w_reg_n;
      r_rem   <= w_rem_n;
      r_dir   <= w_dir_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  assign parallelOut = r_reg;
  assign serialOutL  = r_reg[WIDTH-1];
  assign serialOutR  = r_reg[0];
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8, RESET_VAL=0).
// Define USR_ROTATE_EN for both bench and RTL to exercise rotation.
module tb_universal_shift_register;

`ifdef USR_ROTATE_EN
  localparam logic ROT = 1'b1;
`else
  localparam logic ROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] parallelIn = 8'h00;
  logic       serialInL = 1'b0;
  logic       serialInR = 1'b0;
  logic       start = 1'b0;
  logic [3:0] shiftLen = 4'd0;
  logic       dir = 1'b0;
  logic       rotate = 1'b0;
  logic [7:0] parallelOut;
  logic       serialOutL;
  logic       serialOutR;
  logic       busy;
  logic       done;
  logic       o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;
  logic [11:0] exp_q[$];

  universal_shift_register #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .mode(mode), .parallelIn(parallelIn),
    .serialInL(serialInL), .serialInR(serialInR), .start(start),
    .shiftLen(shiftLen), .dir(dir), .rotate(rotate),
    .parallelOut(parallelOut), .serialOutL(serialOutL), .serialOutR(serialOutR),
    .busy(busy), .done(done), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packed expectation: {busy, done, serialOutL, serialOutR, parallelOut}.
  function automatic logic [11:0] ex(input logic b, input logic d, input logic [7:0] v);
    logic [7:0] t;
    t = v;
    return {b, d, t[7], t[0], t};
  endfunction

  task automatic set_in(input logic [1:0] m, input logic [7:0] p, input logic sl,
                        input logic sr, input logic st, input logic [3:0] len,
                        input logic d, input logic r);
    mode = m; parallelIn = p; serialInL = sl; serialInR = sr;
    start = st; shiftLen = len; dir = d; rotate = r;
  endtask

  // Driver: queue the expectation for the coming edge, then move to edge+2.
  task automatic cyc(input logic [11:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares one edge after the driver queued its expectation.
  always @(posedge clk) begin
    logic [11:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cyc++;
      check($sformatf("cyc%0d", n_cyc), {20'd0, busy, done, serialOutL, serialOutR, parallelOut},
            {20'd0, e});
    end
  end

  initial begin
    logic [7:0] mdl;
    logic [1:0] rm;
    logic [7:0] rp;
    logic       rsl, rsr;

    #3;
    check("reset_out",  {24'd0, parallelOut}, 32'h00);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Manual operations
    set_in(2'b11, 8'hA5, 0, 0, 0, 0, 0, 0); cyc(ex(0, 0, 8'hA5));
    set_in(2'b01, 8'h00, 1, 0, 0, 0, 0, 0); cyc(ex(0, 0, 8'h4B));
    set_in(2'b10, 8'h00, 0, 0, 0, 0, 0, 0); cyc(ex(0, 0, 8'h25));
    set_in(2'b00, 8'hFF, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(ex(0, 0, 8'h25));

    // Left burst of 3; mode=11 held throughout must not load
    set_in(2'b11, 8'h81, 0, 0, 0, 0, 0, 0); cyc(ex(0, 0, 8'h81));
    set_in(2'b11, 8'hFF, 0, 0, 1, 4'd3, 0, 0); cyc(ex(1, 0, 8'h81));
    set_in(2'b11, 8'hFF, 0, 0, 0, 4'd0, 1, 0);
    cyc(ex(1, 0, 8'h02));
    cyc(ex(1, 0, 8'h04));
    cyc(ex(0, 1, 8'h08));
    set_in(2'b00, 8'h00, 0, 0, 0, 0, 0, 0); cyc(ex(0, 0, 8'h08));

    // Saturating right burst (12 -> 8) with a dropped start during busy
    set_in(2'b11, 8'h00, 0, 1, 0, 0, 0, 0); cyc(ex(0, 0, 8'h00));
    set_in(2'b00, 8'h00, 0, 1, 1, 4'd12, 1, 0); cyc(ex(1, 0, 8'h00));
    set_in(2'b01, 8'h00, 0, 1, 1, 4'd0, 0, 0);
    for (int k = 1; k < 8; k++) cyc(ex(1, 0, 8'hFF << (8 - k)));
    cyc(ex(0, 1, 8'hFF));
    set_in(2'b00, 8'h00, 0, 0, 0, 0, 0, 0); cyc(ex(0, 0, 8'hFF));

    // Zero-length start: done pulse, no busy, register unchanged
    set_in(2'b11, 8'h00, 0, 0, 1, 4'd0, 0, 0); cyc(ex(0, 1, 8'hFF));
    set_in(2'b00, 8'h00, 0, 0, 0, 0, 0, 0); cyc(ex(0, 0, 8'hFF));

    // Reset in the middle of a burst of 5
    set_in(2'b11, 8'hF0, 0, 0, 0, 0, 0, 0); cyc(ex(0, 0, 8'hF0));
    set_in(2'b00, 8'h00, 0, 0, 1, 4'd5, 0, 0); cyc(ex(1, 0, 8'hF0));
    set_in(2'b00, 8'h00, 0, 0, 0, 0, 0, 0);
    cyc(ex(1, 0, 8'hE0));
    cyc(ex(1, 0, 8'hC0));
    reset = 1'b1;
    #1;
    check("midrst_out",   {24'd0, parallelOut}, 32'h00);
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    check("midrst_state", {31'd0, o_dbg_state}, 32'd0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc(ex(0, 0, 8'h00));

    // Rotation (manual and burst)
    set_in(2'b11, 8'h81, 0, 0, 0, 0, 0, 0); cyc(ex(0, 0, 8'h81));
    set_in(2'b01, 8'h00, 0, 0, 0, 0, 0, 1); cyc(ex(0, 0, ROT ? 8'h03 : 8'h02));
    set_in(2'b10, 8'h00, 0, 0, 0, 0, 0, 1); cyc(ex(0, 0, ROT ? 8'h81 : 8'h01));
    set_in(2'b11, 8'h81, 0, 0, 0, 0, 0, 0); cyc(ex(0, 0, 8'h81));
    set_in(2'b00, 8'h00, 0, 0, 1, 4'd2, 1, 1); cyc(ex(1, 0, 8'h81));
    set_in(2'b00, 8'h00, 0, 0, 0, 0, 0, 1);
    cyc(ex(1, 0, ROT ? 8'hC0 : 8'h40));
    cyc(ex(0, 1, ROT ? 8'h60 : 8'h20));
    set_in(2'b00, 8'h00, 0, 0, 0, 0, 0, 0); cyc(ex(0, 0, ROT ? 8'h60 : 8'h20));

    // Random manual operations against a small arithmetic model
    mdl = ROT ? 8'h60 : 8'h20;
    for (int i = 0; i < 40; i++) begin
      rm  = 2'($urandom_range(0, 3));
      rp  = 8'($urandom_range(0, 255));
      rsl = 1'($urandom_range(0, 1));
      rsr = 1'($urandom_range(0, 1));
      case (rm)
        2'b01:   mdl = 8'((mdl * 2) + rsl);
        2'b10:   mdl = 8'((mdl / 2) + (rsr ? 128 : 0));
        2'b11:   mdl = rp;
        default: mdl = mdl;
      endcase
      set_in(rm, rp, rsl, rsr, 0, 0, 0, 0);
      cyc(ex(0, 0, mdl));
    end

    @(posedge clk);
    #2;
    check("drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
